mdu_e: RTL

Multiply/divide unit for the execute stage of the five-stage pipelined MIPS CPU. It sits beside the E-stage ALU and takes forwarded rs/rt operands from E. It implements mult/multu/div/divu with fixed multi-cycle latency, plus mthi/mtlo, and holds the architectural HI/LO registers. HI/LO feed the M-stage result mux for mfhi/mflo. The `busy` output goes to the hazard unit, which stalls D while a multiply/divide op is in flight.

---
 rtl/mdu_e.sv | 110 +++++++++++
 1 files changed

// File: rtl/mdu_e.sv
// Multiply/divide unit for the E stage: holds architectural HI/LO and runs mult/div ops
// with a fixed busy latency so the hazard unit can stall D while an op is in flight.
module mdu_e #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e      state;
  logic [31:0] cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_wr;

  logic        is_signed;
  logic        is_div;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic [63:0] prod;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic [31:0] quot;
  logic [31:0] rem;

  // Result is computed at the start edge and parked until the completion edge.
  always_comb begin
    is_signed = ~md_op[0];
    is_div    = md_op[1];
    // Extending to 64 bits makes a single low-64 product correct for both signednesses.
    op_a  = {{32{is_signed & rs_data[31]}}, rs_data};
    op_b  = {{32{is_signed & rt_data[31]}}, rt_data};
    prod  = op_a * op_b;
    // Signed divide on magnitudes avoids the 0x80000000 / -1 overflow corner entirely.
    neg_a = is_signed & rs_data[31];
    neg_b = is_signed & rt_data[31];
    mag_a = neg_a ? (32'd0 - rs_data) : rs_data;
    mag_b = neg_b ? (32'd0 - rt_data) : rt_data;
    if (rt_data == 32'd0) begin
      div_q = 32'd0;
      div_r = 32'd0;
    end else begin
      div_q = mag_a / mag_b;
      div_r = mag_a % mag_b;
    end
    quot = (neg_a ^ neg_b) ? (32'd0 - div_q) : div_q;
    rem  = neg_a ? (32'd0 - div_r) : div_r;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= StIdle;
      busy    <= 1'b0;
      cnt     <= 32'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            case (md_op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                state   <= StRun;
                busy    <= 1'b1;
                cnt     <= is_div ? DIV_CYCLES : MULT_CYCLES;
                pend_hi <= is_div ? rem : prod[63:32];
                pend_lo <= is_div ? quot : prod[31:0];
                // Divide by zero still occupies the unit but leaves HI/LO untouched.
                pend_wr <= ~(is_div & (rt_data == 32'd0));
              end
              3'd4:    hi <= rs_data;
              3'd5:    lo <= rs_data;
              default: ;
            endcase
          end
        end
        StRun: begin
          cnt <= cnt - 32'd1;
          if (cnt == 32'd1) begin
            state <= StIdle;
            busy  <= 1'b0;
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
